// File: rtl/mem_responder.sv
// Byte-addressed memory slave answering each request after WAIT_CYCLES wait states.
// Define MEM_RESPONDER_MISALIGN_EN to report misaligned or reserved-size accesses.
module mem_responder #(
    parameter int unsigned WAIT_CYCLES = 2,
    parameter int unsigned DEPTH_BYTES = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic        sign,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        ack,
    output logic [31:0] rdata,
    output logic        misalign,
    output logic        busy
);
    localparam int unsigned AW        = $clog2(DEPTH_BYTES);
    localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_e;

    state_e        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          wr_q, wr_d;
    logic [1:0]    size_q, size_d;
    logic          sign_q, sign_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;

    logic [7:0]    mem_q [DEPTH_BYTES];
    logic [3:0]    mem_we;
    logic [AW-1:0] wr_base;
    logic [AW-1:0] rd_base;
    logic [31:0]   rd_word;
    logic          err_d;
    logic          err_cur;
    logic          unused_addr_hi;

    assign unused_addr_hi = ^addr[31:AW];

    // Halfword and word accesses always land on their natural boundary; size 11 acts as word.
    function automatic logic [AW-1:0] align_addr(input logic [1:0] sz, input logic [AW-1:0] a);
        logic [AW-1:0] r;
        r = a;
        if (sz == SZ_HALF) begin
            r[0] = 1'b0;
        end else if (sz != SZ_BYTE) begin
            r[1:0] = 2'b00;
        end
        return r;
    endfunction

    function automatic logic [3:0] lane_mask(input logic [1:0] sz);
        case (sz)
            SZ_HALF: return 4'b0011;
            SZ_BYTE: return 4'b0001;
            default: return 4'b1111;
        endcase
    endfunction

`ifdef MEM_RESPONDER_MISALIGN_EN
    function automatic logic access_err(input logic [1:0] sz, input logic [1:0] a_lo);
        return (sz == 2'b11) || (sz == SZ_HALF && a_lo[0]) || (sz == SZ_WORD && a_lo != 2'b00);
    endfunction

    assign err_d   = access_err(size_d, addr_d[1:0]);
    assign err_cur = access_err(size_q, addr_q[1:0]);
`else
    assign err_d   = 1'b0;
    assign err_cur = 1'b0;
`endif

    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        size_d  = size_q;
        sign_d  = sign_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    wr_d    = wr;
                    size_d  = size;
                    sign_d  = sign;
                    addr_d  = addr[AW-1:0];
                    wdata_d = wdata;
                    if (WAIT_INIT == 4'd0) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = WAIT_INIT;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            wr_q    <= 1'b0;
            size_q  <= 2'b00;
            sign_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            size_q  <= size_d;
            sign_q  <= sign_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    // Stores commit on the edge entering RESP; the _d values cover the zero-wait IDLE->RESP hop.
    always_comb begin
        wr_base = align_addr(size_d, addr_d);
        mem_we  = 4'b0000;
        if (rst_n && state_d == RESP && state_q != RESP && wr_d && !err_d) begin
            mem_we = lane_mask(size_d);
        end
    end

    // NOTE: the storage array has no reset; its contents survive rst_n and it can map onto a RAM.
    always_ff @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (mem_we[k]) begin
                mem_q[wr_base + AW'(k)] <= wdata_d[8*k +: 8];
            end
        end
    end

    always_comb begin
        rd_base = align_addr(size_q, addr_q);
        rd_word = 32'd0;
        for (int k = 0; k < 4; k++) begin
            rd_word[8*k +: 8] = mem_q[rd_base + AW'(k)];
        end
        ack      = (state_q == RESP);
        busy     = (state_q != IDLE);
        misalign = 1'b0;
        rdata    = 32'd0;
        if (state_q == RESP) begin
            if (err_cur) begin
                misalign = 1'b1;
            end else if (!wr_q) begin
                case (size_q)
                    SZ_HALF: rdata = {{16{sign_q & rd_word[15]}}, rd_word[15:0]};
                    SZ_BYTE: rdata = {{24{sign_q & rd_word[7]}}, rd_word[7:0]};
                    default: rdata = rd_word;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: a WAIT_CYCLES=2 instance for the access/extension/error
// scenarios and a WAIT_CYCLES=0 instance for back-to-back requests.
module tb_mem_responder;
`ifdef MEM_RESPONDER_MISALIGN_EN
    localparam bit MIS_EN = 1'b1;
`else
    localparam bit MIS_EN = 1'b0;
`endif
    localparam int LAT = 3;

    typedef struct packed {
        logic [1:0]  sz;
        logic        sg;
        logic [31:0] a;
        logic [31:0] exp;
    } ld_t;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic        req = 1'b0, wr = 1'b0, sign = 1'b0;
    logic [1:0]  size  = 2'b00;
    logic [31:0] addr  = 32'd0, wdata = 32'd0;
    logic        ack, misalign, busy;
    logic [31:0] rdata;
    logic        req0 = 1'b0, wr0 = 1'b0, sign0 = 1'b0;
    logic [1:0]  size0  = 2'b00;
    logic [31:0] addr0  = 32'd0, wdata0 = 32'd0;
    logic        ack0, misalign0, busy0;
    logic [31:0] rdata0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_responder #(.WAIT_CYCLES(2), .DEPTH_BYTES(256)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .wr(wr), .size(size), .sign(sign),
        .addr(addr), .wdata(wdata), .ack(ack), .rdata(rdata), .misalign(misalign), .busy(busy)
    );

    mem_responder #(.WAIT_CYCLES(0), .DEPTH_BYTES(256)) dut0 (
        .clk(clk), .rst_n(rst_n), .req(req0), .wr(wr0), .size(size0), .sign(sign0),
        .addr(addr0), .wdata(wdata0), .ack(ack0), .rdata(rdata0), .misalign(misalign0), .busy(busy0)
    );

    // One transaction on dut; inputs are scrambled after acceptance to show they are ignored.
    task automatic access(input logic w, input logic [1:0] sz, input logic sg, input logic [31:0] a,
                          input logic [31:0] d, output int lat, output logic [31:0] rd,
                          output logic mis, output logic bsy, output logic clean);
        req = 1'b1; wr = w; size = sz; sign = sg; addr = a; wdata = d;
        @(posedge clk);
        #1;
        wr = ~w; size = ~sz; sign = ~sg; addr = ~a; wdata = ~d;
        lat = -1; rd = 32'hxxxx_xxxx; mis = 1'bx; bsy = 1'bx; clean = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (ack === 1'b1) begin
                lat = c; rd = rdata; mis = misalign; bsy = busy;
                break;
            end
            if (rdata !== 32'd0 || misalign !== 1'b0 || busy !== 1'b1) clean = 1'b0;
        end
        req = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        total++; if (ack !== 1'b0) begin bad++; $display("FAIL reset_ack: got %b want 0", ack); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (rdata !== 32'd0) begin bad++; $display("FAIL reset_rdata: got %h want 0", rdata); end
        total++; if (misalign !== 1'b0) begin bad++; $display("FAIL reset_misalign: got %b want 0", misalign); end
        total++; if (ack0 !== 1'b0 || busy0 !== 1'b0) begin bad++; $display("FAIL reset_dut0: got ack=%b busy=%b want 0 0", ack0, busy0); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_store_load();
        int lat; logic [31:0] rd; logic mis, bsy, clean;
        access(1'b1, 2'b00, 1'b0, 32'h10, 32'hDEAD_BEEF, lat, rd, mis, bsy, clean);
        total++; if (lat !== LAT) begin bad++; $display("FAIL store_latency: got %0d want %0d", lat, LAT); end
        total++; if (rd !== 32'd0 || mis !== 1'b0) begin bad++; $display("FAIL store_resp: got rdata=%h mis=%b want 0 0", rd, mis); end
        total++; if (bsy !== 1'b1) begin bad++; $display("FAIL store_busy_at_ack: got %b want 1", bsy); end
        total++; if (clean !== 1'b1) begin bad++; $display("FAIL wait_outputs: got clean=%b want 1", clean); end
        access(1'b0, 2'b00, 1'b0, 32'h10, 32'd0, lat, rd, mis, bsy, clean);
        total++; if (lat !== LAT) begin bad++; $display("FAIL load_latency: got %0d want %0d", lat, LAT); end
        total++; if (rd !== 32'hDEAD_BEEF || mis !== 1'b0) begin bad++; $display("FAIL load_word: got %h mis=%b want deadbeef 0", rd, mis); end
    endtask

    task automatic test_extend();
        int lat; logic [31:0] rd; logic mis, bsy, clean;
        ld_t v [5];
        v[0] = '{2'b10, 1'b1, 32'h13, 32'hFFFF_FFDE};
        v[1] = '{2'b10, 1'b0, 32'h13, 32'h0000_00DE};
        v[2] = '{2'b01, 1'b1, 32'h10, 32'hFFFF_BEEF};
        v[3] = '{2'b01, 1'b0, 32'h10, 32'h0000_BEEF};
        v[4] = '{2'b10, 1'b1, 32'h10, 32'hFFFF_FFEF};
        for (int i = 0; i < 5; i++) begin
            access(1'b0, v[i].sz, v[i].sg, v[i].a, 32'd0, lat, rd, mis, bsy, clean);
            total++;
            if (rd !== v[i].exp || mis !== 1'b0) begin
                bad++; $display("FAIL extend_%0d: got %h mis=%b want %h 0", i, rd, mis, v[i].exp);
            end
        end
    endtask

    task automatic test_partial_store();
        int lat; logic [31:0] rd; logic mis, bsy, clean;
        access(1'b1, 2'b01, 1'b0, 32'h12, 32'hFFFF_1234, lat, rd, mis, bsy, clean);
        access(1'b0, 2'b00, 1'b0, 32'h10, 32'd0, lat, rd, mis, bsy, clean);
        total++; if (rd !== 32'h1234_BEEF) begin bad++; $display("FAIL half_store: got %h want 1234beef", rd); end
        access(1'b1, 2'b10, 1'b0, 32'h10, 32'h1234_56AA, lat, rd, mis, bsy, clean);
        access(1'b0, 2'b00, 1'b0, 32'h10, 32'd0, lat, rd, mis, bsy, clean);
        total++; if (rd !== 32'h1234_BEAA) begin bad++; $display("FAIL byte_store: got %h want 1234beaa", rd); end
    endtask

    task automatic test_misalign();
        int lat; logic [31:0] rd; logic mis, bsy, clean;
        access(1'b1, 2'b00, 1'b0, 32'h11, 32'hCAFE_F00D, lat, rd, mis, bsy, clean);
        total++; if (lat !== LAT) begin bad++; $display("FAIL mis_latency: got %0d want %0d", lat, LAT); end
        total++; if (mis !== MIS_EN || rd !== 32'd0) begin bad++; $display("FAIL mis_store: got mis=%b rdata=%h want %b 0", mis, rd, MIS_EN); end
        access(1'b0, 2'b00, 1'b0, 32'h10, 32'd0, lat, rd, mis, bsy, clean);
        total++;
        if (rd !== (MIS_EN ? 32'h1234_BEAA : 32'hCAFE_F00D) || mis !== 1'b0) begin
            bad++; $display("FAIL mis_word_after: got %h mis=%b want %h 0", rd, mis, MIS_EN ? 32'h1234_BEAA : 32'hCAFE_F00D);
        end
        access(1'b0, 2'b01, 1'b1, 32'h13, 32'd0, lat, rd, mis, bsy, clean);
        total++;
        if (rd !== (MIS_EN ? 32'd0 : 32'hFFFF_CAFE) || mis !== MIS_EN) begin
            bad++; $display("FAIL mis_half_load: got %h mis=%b want %h %b", rd, mis, MIS_EN ? 32'd0 : 32'hFFFF_CAFE, MIS_EN);
        end
        access(1'b0, 2'b11, 1'b0, 32'h10, 32'd0, lat, rd, mis, bsy, clean);
        total++;
        if (rd !== (MIS_EN ? 32'd0 : 32'hCAFE_F00D) || mis !== MIS_EN) begin
            bad++; $display("FAIL size11_load: got %h mis=%b want %h %b", rd, mis, MIS_EN ? 32'd0 : 32'hCAFE_F00D, MIS_EN);
        end
    endtask

    task automatic test_wrap();
        int lat; logic [31:0] rd; logic mis, bsy, clean;
        access(1'b1, 2'b00, 1'b0, 32'h1FC, 32'h0BAD_F00D, lat, rd, mis, bsy, clean);
        access(1'b0, 2'b00, 1'b0, 32'hFC, 32'd0, lat, rd, mis, bsy, clean);
        total++; if (rd !== 32'h0BAD_F00D || mis !== 1'b0) begin bad++; $display("FAIL top_word: got %h mis=%b want 0badf00d 0", rd, mis); end
        access(1'b0, 2'b10, 1'b0, 32'hFFFF_FFFF, 32'd0, lat, rd, mis, bsy, clean);
        total++; if (rd !== 32'h0000_000B) begin bad++; $display("FAIL wrap_byte: got %h want 0000000b", rd); end
        access(1'b0, 2'b10, 1'b1, 32'hFE, 32'd0, lat, rd, mis, bsy, clean);
        total++; if (rd !== 32'hFFFF_FFAD) begin bad++; $display("FAIL top_byte_sext: got %h want ffffffad", rd); end
    endtask

    task automatic test_reset_in_wait();
        int lat; logic [31:0] rd; logic mis, bsy, clean;
        logic seen;
        access(1'b1, 2'b00, 1'b0, 32'h20, 32'h7777_7777, lat, rd, mis, bsy, clean);
        req = 1'b1; wr = 1'b1; size = 2'b00; sign = 1'b0; addr = 32'h20; wdata = 32'h55;
        @(posedge clk);
        #1;
        req = 1'b0; wdata = 32'd0;
        @(negedge clk);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL wait_busy: got %b want 1", busy); end
        rst_n = 1'b0;
        #1;
        total++; if (busy !== 1'b0 || ack !== 1'b0) begin bad++; $display("FAIL async_reset_wait: got busy=%b ack=%b want 0 0", busy, ack); end
        seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (ack === 1'b1) seen = 1'b1;
        end
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (ack === 1'b1) seen = 1'b1;
        end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL abandoned_ack: got %b want 0", seen); end
        @(posedge clk);
        #1;
        access(1'b0, 2'b00, 1'b0, 32'h20, 32'd0, lat, rd, mis, bsy, clean);
        total++; if (rd !== 32'h7777_7777) begin bad++; $display("FAIL abandoned_store: got %h want 77777777", rd); end

        req = 1'b1; wr = 1'b0; size = 2'b00; sign = 1'b0; addr = 32'h20;
        @(posedge clk);
        #1;
        addr = 32'd0;
        seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (ack === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        req = 1'b0;
        total++; if (seen !== 1'b1 || rdata !== 32'h7777_7777) begin bad++; $display("FAIL ack_before_reset: got ack=%b rdata=%h want 1 77777777", seen, rdata); end
        rst_n = 1'b0;
        #1;
        total++;
        if (ack !== 1'b0 || rdata !== 32'd0 || busy !== 1'b0) begin
            bad++; $display("FAIL async_reset_ack: got ack=%b rdata=%h busy=%b want 0 0 0", ack, rdata, busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        logic [5:0]  ack_seq;
        logic [5:0]  busy_seq;
        logic [31:0] rd_ack;
        logic [31:0] rd_gap;
        ack_seq = '0; busy_seq = '0; rd_ack = '0; rd_gap = '1;
        req0 = 1'b1; wr0 = 1'b1; size0 = 2'b00; sign0 = 1'b0; addr0 = 32'h40; wdata0 = 32'h1122_3344;
        @(posedge clk);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            ack_seq[i]  = ack0;
            busy_seq[i] = busy0;
            if (i == 0) wr0 = 1'b0;
            if (i == 2) rd_ack = rdata0;
            if (i == 3) rd_gap = rdata0;
        end
        req0 = 1'b0;
        total++; if (ack_seq !== 6'b010101) begin bad++; $display("FAIL b2b_ack: got %b want 010101", ack_seq); end
        total++; if (busy_seq !== 6'b010101) begin bad++; $display("FAIL b2b_busy: got %b want 010101", busy_seq); end
        total++; if (rd_ack !== 32'h1122_3344) begin bad++; $display("FAIL b2b_load: got %h want 11223344", rd_ack); end
        total++; if (rd_gap !== 32'd0) begin bad++; $display("FAIL b2b_idle_rdata: got %h want 0", rd_gap); end
        @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_extend();
        test_partial_store();
        test_misalign();
        test_wrap();
        test_reset_in_wait();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "timeout");
    end
endmodule
